// File: rtl/pipe_addsub_lanes_if.sv
// Handshake and lane bus for pipe_addsub_lanes: producer-side operands,
// consumer-side results, flow control in both directions.
interface pipe_addsub_lanes_if #(
    parameter int W     = 12,
    parameter int LANES = 2
);
    logic               start;
    logic               in_ready;
    logic               mode;
    logic [LANES*W-1:0] a;
    logic [LANES*W-1:0] b;
    logic [LANES*W-1:0] y;
    logic [LANES-1:0]   ovf;
    logic               valid;
    logic               out_ready;
    logic               busy;

    modport master (
        output start, mode, a, b, out_ready,
        input  in_ready, y, ovf, valid, busy
    );

    modport slave (
        input  start, mode, a, b, out_ready,
        output in_ready, y, ovf, valid, busy
    );
endinterface

// File: rtl/pipe_addsub_lanes.sv
// Multi-lane unsigned add/subtract pipeline, DEPTH stages, global stall on backpressure.
// Optional PIPE_ADDSUB_SAT_EN: lane results saturate instead of wrapping.
module pipe_addsub_lanes #(
    parameter int W     = 12,
    parameter int LANES = 2,
    parameter int DEPTH = 2
) (
    input logic                clk,
    input logic                rst,
    pipe_addsub_lanes_if.slave bus
);
    localparam int DW = LANES * W;

    logic             stall;
    logic [W:0]       lane_sum;
    logic [DW-1:0]    calc_y;
    logic [LANES-1:0] calc_ovf;
    logic [DW-1:0]    stage_y   [DEPTH];
    logic [LANES-1:0] stage_ovf [DEPTH];
    logic [DEPTH-1:0] stage_vld;

    assign stall = stage_vld[DEPTH-1] && !bus.out_ready;

    // Each lane is computed one bit wider so the top bit is carry (add) or borrow (sub).
    always_comb begin
        lane_sum = '0;
        calc_y   = '0;
        calc_ovf = '0;
        for (int i = 0; i < LANES; i++) begin
            if (bus.mode) begin
                lane_sum = {1'b0, bus.a[i*W +: W]} - {1'b0, bus.b[i*W +: W]};
            end else begin
                lane_sum = {1'b0, bus.a[i*W +: W]} + {1'b0, bus.b[i*W +: W]};
            end
            calc_ovf[i] = lane_sum[W];
`ifdef PIPE_ADDSUB_SAT_EN
            if (lane_sum[W]) begin
                calc_y[i*W +: W] = bus.mode ? {W{1'b0}} : {W{1'b1}};
            end else begin
                calc_y[i*W +: W] = lane_sum[W-1:0];
            end
`else
            calc_y[i*W +: W] = lane_sum[W-1:0];
`endif
        end
    end

    // Data registers only load behind a valid bit, so bubbles leave old data in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_vld <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                stage_y[s]   <= '0;
                stage_ovf[s] <= '0;
            end
        end else if (!stall) begin
            stage_vld[0] <= bus.start;
            if (bus.start) begin
                stage_y[0]   <= calc_y;
                stage_ovf[0] <= calc_ovf;
            end
            for (int s = 1; s < DEPTH; s++) begin
                stage_vld[s] <= stage_vld[s-1];
                if (stage_vld[s-1]) begin
                    stage_y[s]   <= stage_y[s-1];
                    stage_ovf[s] <= stage_ovf[s-1];
                end
            end
        end
    end

    assign bus.in_ready = !stall;
    assign bus.y        = stage_y[DEPTH-1];
    assign bus.ovf      = stage_ovf[DEPTH-1];
    assign bus.valid    = stage_vld[DEPTH-1];
    assign bus.busy     = |stage_vld;
endmodule

// File: tb/tb_pipe_addsub_lanes.sv
// Directed self-checking bench for pipe_addsub_lanes; DEPTH=2 main instance plus
// DEPTH=1 and DEPTH=4 instances sharing the same stimulus for the latency sweep.
module tb_pipe_addsub_lanes;
    localparam int W     = 12;
    localparam int LANES = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        out_ready = 1'b1;
    logic [23:0] a = '0;
    logic [23:0] b = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_addsub_lanes_if #(.W(W), .LANES(LANES)) bus1 ();
    pipe_addsub_lanes_if #(.W(W), .LANES(LANES)) bus2 ();
    pipe_addsub_lanes_if #(.W(W), .LANES(LANES)) bus4 ();

    assign bus1.start = start;
    assign bus1.mode = mode;
    assign bus1.a = a;
    assign bus1.b = b;
    assign bus1.out_ready = out_ready;
    assign bus2.start = start;
    assign bus2.mode = mode;
    assign bus2.a = a;
    assign bus2.b = b;
    assign bus2.out_ready = out_ready;
    assign bus4.start = start;
    assign bus4.mode = mode;
    assign bus4.a = a;
    assign bus4.b = b;
    assign bus4.out_ready = out_ready;

    pipe_addsub_lanes #(.W(W), .LANES(LANES), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .bus(bus2)
    );
    pipe_addsub_lanes #(.W(W), .LANES(LANES), .DEPTH(1)) dut_d1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    pipe_addsub_lanes #(.W(W), .LANES(LANES), .DEPTH(4)) dut_d4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );

    logic [2:0]  sw_valid;
    logic [23:0] sw_y [3];
    assign sw_valid = {bus4.valid, bus2.valid, bus1.valid};
    assign sw_y[0] = bus1.y;
    assign sw_y[1] = bus2.y;
    assign sw_y[2] = bus4.y;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic m, input logic [11:0] a0,
                                 input logic [11:0] b0, input logic [11:0] a1,
                                 input logic [11:0] b1);
        start = s;
        mode  = m;
        a     = {a1, a0};
        b     = {b1, b0};
    endtask

    // Presents one transfer and waits (bounded) for its result on the DEPTH=2 instance.
    task automatic transact(input logic m, input logic [11:0] a0, input logic [11:0] b0,
                            input logic [11:0] a1, input logic [11:0] b1,
                            output logic [23:0] yo, output logic [1:0] ovo, output int lat);
        applyStimulus(1'b1, m, a0, b0, a1, b1);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 12'h0, 12'h0, 12'h0, 12'h0);
        lat = 1;
        while (bus2.valid !== 1'b1 && lat < 10) begin
            next_cycle();
            lat++;
        end
        if (bus2.valid !== 1'b1) lat = -1;
        yo  = bus2.y;
        ovo = bus2.ovf;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 12'h0, 12'h0, 12'h0, 12'h0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        checks++;
        if (bus2.valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", bus2.valid); end
        checks++;
        if (bus2.y !== 24'h0) begin errors++; $display("[TB] FAIL reset_y: got %h expected 000000", bus2.y); end
        checks++;
        if (bus2.ovf !== 2'b00) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 00", bus2.ovf); end
        checks++;
        if (bus2.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", bus2.busy); end
        checks++;
        if (bus2.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", bus2.in_ready); end
        next_cycle();
    endtask

    task automatic test_add;
        logic [23:0] yo;
        logic [1:0]  ovo;
        int          lat;
        transact(1'b0, 12'h7FF, 12'h001, 12'h123, 12'h456, yo, ovo, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("[TB] FAIL add_latency: got %0d edges expected 2", lat); end
        checks++;
        if (yo !== {12'h579, 12'h800}) begin errors++; $display("[TB] FAIL add_y: got %h expected 579800", yo); end
        checks++;
        if (ovo !== 2'b00) begin errors++; $display("[TB] FAIL add_ovf: got %b expected 00", ovo); end
        next_cycle();
        checks++;
        if (bus2.valid !== 1'b0) begin errors++; $display("[TB] FAIL add_single_valid: got %0b expected 0", bus2.valid); end
    endtask

    task automatic test_add_overflow;
        logic [23:0] yo;
        logic [1:0]  ovo;
        logic [11:0] exp0;
        int          lat;
`ifdef PIPE_ADDSUB_SAT_EN
        exp0 = 12'hFFF;
`else
        exp0 = 12'h001;
`endif
        transact(1'b0, 12'hFFF, 12'h002, 12'h000, 12'h000, yo, ovo, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("[TB] FAIL addovf_latency: got %0d edges expected 2", lat); end
        checks++;
        if (yo !== {12'h000, exp0}) begin errors++; $display("[TB] FAIL addovf_y: got %h expected %h", yo, {12'h000, exp0}); end
        checks++;
        if (ovo !== 2'b01) begin errors++; $display("[TB] FAIL addovf_ovf: got %b expected 01", ovo); end
        next_cycle();
    endtask

    task automatic test_sub_borrow;
        logic [23:0] yo;
        logic [1:0]  ovo;
        logic [11:0] exp0;
        int          lat;
`ifdef PIPE_ADDSUB_SAT_EN
        exp0 = 12'h000;
`else
        exp0 = 12'hFFD;
`endif
        transact(1'b1, 12'h005, 12'h008, 12'h800, 12'h001, yo, ovo, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("[TB] FAIL sub_latency: got %0d edges expected 2", lat); end
        checks++;
        if (yo !== {12'h7FF, exp0}) begin errors++; $display("[TB] FAIL sub_y: got %h expected %h", yo, {12'h7FF, exp0}); end
        checks++;
        if (ovo !== 2'b01) begin errors++; $display("[TB] FAIL sub_ovf: got %b expected 01", ovo); end
        next_cycle();
    endtask

    // Six transfers; out_ready drops for three cycles from the first valid.
    task automatic test_backpressure;
        int sent = 0;
        int got = 0;
        int stall_left = 0;
        int extra = 0;
        bit first_seen = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            if (sent < 6) applyStimulus(1'b1, 1'b0, 12'(sent + 1), 12'h0, 12'(16 * (sent + 1)), 12'h0);
            else          applyStimulus(1'b0, 1'b0, 12'h0, 12'h0, 12'h0, 12'h0);
            if (bus2.valid === 1'b1 && !first_seen) begin
                first_seen = 1'b1;
                stall_left = 3;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (!out_ready) begin
                checks++;
                if (bus2.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready: got %0b expected 0 in cycle %0d", bus2.in_ready, cyc); end
                checks++;
                if (bus2.y[11:0] !== 12'h001) begin errors++; $display("[TB] FAIL bp_hold_y: got %h expected 001 in cycle %0d", bus2.y[11:0], cyc); end
            end
            if (bus2.valid === 1'b1 && out_ready) begin
                got++;
                checks++;
                if (bus2.y !== {12'(16 * got), 12'(got)} || bus2.ovf !== 2'b00) begin
                    errors++;
                    $display("[TB] FAIL bp_order: got y=%h ovf=%b expected y=%h ovf=00", bus2.y, bus2.ovf, {12'(16 * got), 12'(got)});
                end
            end
            if (start && bus2.in_ready) sent++;
            next_cycle();
        end
        out_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 12'h0, 12'h0, 12'h0, 12'h0);
        checks++;
        if (got !== 6) begin errors++; $display("[TB] FAIL bp_count: got %0d results expected 6", got); end
        for (int k = 0; k < 5; k++) begin
            if (bus2.valid === 1'b1) extra++;
            next_cycle();
        end
        checks++;
        if (extra !== 0) begin errors++; $display("[TB] FAIL bp_duplicates: got %0d extra results expected 0", extra); end
    endtask

    // Eight back-to-back transfers into DEPTH 1, 2 and 4 instances.
    task automatic test_streaming_depth;
        int depths [3] = '{1, 2, 4};
        int first [3]  = '{-1, -1, -1};
        int cnt [3]    = '{0, 0, 0};
        int last [3]   = '{-1, -1, -1};
        rst = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 12'h0, 12'h0, 12'h0, 12'h0);
        next_cycle();
        rst = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc < 8) applyStimulus(1'b1, 1'b0, 12'(16 + cyc), 12'(cyc), 12'(cyc), 12'h001);
            else         applyStimulus(1'b0, 1'b0, 12'h0, 12'h0, 12'h0, 12'h0);
            for (int j = 0; j < 3; j++) begin
                if (sw_valid[j] === 1'b1) begin
                    if (first[j] < 0) first[j] = cyc;
                    checks++;
                    if (sw_y[j] !== {12'(cnt[j] + 1), 12'(16 + 2 * cnt[j])}) begin
                        errors++;
                        $display("[TB] FAIL stream_d%0d_y: got %h expected %h", depths[j], sw_y[j], {12'(cnt[j] + 1), 12'(16 + 2 * cnt[j])});
                    end
                    cnt[j]++;
                    last[j] = cyc;
                end
            end
            next_cycle();
        end
        applyStimulus(1'b0, 1'b0, 12'h0, 12'h0, 12'h0, 12'h0);
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (first[j] !== depths[j]) begin errors++; $display("[TB] FAIL stream_d%0d_first: got cycle %0d expected %0d", depths[j], first[j], depths[j]); end
            checks++;
            if (cnt[j] !== 8) begin errors++; $display("[TB] FAIL stream_d%0d_count: got %0d expected 8", depths[j], cnt[j]); end
            checks++;
            if (last[j] !== depths[j] + 7) begin errors++; $display("[TB] FAIL stream_d%0d_contig: got last %0d expected %0d", depths[j], last[j], depths[j] + 7); end
        end
    endtask

    task automatic test_reset_mid;
        int seen2 = 0;
        int seen4 = 0;
        out_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 12'hFFF, 12'hFFF, 12'hABC, 12'h111);
        next_cycle();
        applyStimulus(1'b1, 1'b0, 12'h555, 12'hAAA, 12'hF00, 12'h200);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 12'h0, 12'h0, 12'h0, 12'h0);
        checks++;
        if (bus4.busy !== 1'b1 || bus4.valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_pre: got busy=%0b valid=%0b expected busy=1 valid=0", bus4.busy, bus4.valid);
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        checks++;
        if (bus4.valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_d4_valid: got %0b expected 0", bus4.valid); end
        checks++;
        if (bus4.y !== 24'h0) begin errors++; $display("[TB] FAIL midrst_d4_y: got %h expected 000000", bus4.y); end
        checks++;
        if (bus4.ovf !== 2'b00) begin errors++; $display("[TB] FAIL midrst_d4_ovf: got %b expected 00", bus4.ovf); end
        checks++;
        if (bus4.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_d4_busy: got %0b expected 0", bus4.busy); end
        checks++;
        if (bus4.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_d4_in_ready: got %0b expected 1", bus4.in_ready); end
        checks++;
        if (bus2.valid !== 1'b0 || bus2.y !== 24'h0 || bus2.ovf !== 2'b00 || bus2.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_d2_state: got valid=%0b y=%h ovf=%b busy=%0b expected all 0", bus2.valid, bus2.y, bus2.ovf, bus2.busy);
        end
        for (int k = 0; k < 8; k++) begin
            if (bus4.valid === 1'b1) seen4++;
            if (bus2.valid === 1'b1) seen2++;
            next_cycle();
        end
        checks++;
        if (seen4 !== 0) begin errors++; $display("[TB] FAIL midrst_d4_ghost: got %0d results expected 0", seen4); end
        checks++;
        if (seen2 !== 0) begin errors++; $display("[TB] FAIL midrst_d2_ghost: got %0d results expected 0", seen2); end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_add();
        test_add_overflow();
        test_sub_borrow();
        test_backpressure();
        test_streaming_depth();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
